// File: rtl/oifs_tx_mux.sv
// Two-channel byte mux: per-channel FIFOs, round-robin arbiter, registered valid-ready output.
// Optional per-channel transfer counters enabled by defining OIFS_TX_MUX_STATS_EN.
module oifs_tx_mux #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 3
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic              i_a_valid,
    input  logic [DATA_W-1:0] i_a_data,
    output logic              o_a_ready,
    input  logic              i_b_valid,
    input  logic [DATA_W-1:0] i_b_data,
    output logic              o_b_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_channel,
    input  logic              i_ready
`ifdef OIFS_TX_MUX_STATS_EN
    ,
    output logic [15:0]       o_a_count,
    output logic [15:0]       o_b_count
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic [FIFO_AW:0]  a_wp, a_rp, b_wp, b_rp;
    logic              a_full, b_full, a_empty, b_empty;
    logic              push_a, push_b, pick_a, pick_b, ld, r_last;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign a_full  = (a_wp[FIFO_AW-1:0] == a_rp[FIFO_AW-1:0]) && (a_wp[FIFO_AW] != a_rp[FIFO_AW]);
    assign b_full  = (b_wp[FIFO_AW-1:0] == b_rp[FIFO_AW-1:0]) && (b_wp[FIFO_AW] != b_rp[FIFO_AW]);
    assign a_empty = (a_wp == a_rp);
    assign b_empty = (b_wp == b_rp);

    assign o_a_ready = !a_full;
    assign o_b_ready = !b_full;
    assign push_a    = i_a_valid && o_a_ready;
    assign push_b    = i_b_valid && o_b_ready;
    assign ld        = !o_valid || i_ready;

    always_comb begin
        pick_a = 1'b0;
        pick_b = 1'b0;
        if (ld) begin
            if (!a_empty && !b_empty) begin
                pick_a = r_last;
                pick_b = !r_last;
            end else if (!a_empty) begin
                pick_a = 1'b1;
            end else if (!b_empty) begin
                pick_b = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_a) mem_a[a_wp[FIFO_AW-1:0]] <= i_a_data;
        if (push_b) mem_b[b_wp[FIFO_AW-1:0]] <= i_b_data;
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            a_wp <= '0;
            a_rp <= '0;
            b_wp <= '0;
            b_rp <= '0;
        end else begin
            if (push_a) a_wp <= a_wp + PTR_ONE;
            if (push_b) b_wp <= b_wp + PTR_ONE;
            if (pick_a) a_rp <= a_rp + PTR_ONE;
            if (pick_b) b_rp <= b_rp + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_channel <= 1'b0;
            r_last    <= 1'b1;
        end else if (ld) begin
            if (pick_a) begin
                o_valid   <= 1'b1;
                o_data    <= mem_a[a_rp[FIFO_AW-1:0]];
                o_channel <= 1'b0;
                r_last    <= 1'b0;
            end else if (pick_b) begin
                o_valid   <= 1'b1;
                o_data    <= mem_b[b_rp[FIFO_AW-1:0]];
                o_channel <= 1'b1;
                r_last    <= 1'b1;
            end else begin
                o_valid   <= 1'b0;
            end
        end
    end

`ifdef OIFS_TX_MUX_STATS_EN
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_a_count <= '0;
            o_b_count <= '0;
        end else if (o_valid && i_ready) begin
            if (o_channel) o_b_count <= o_b_count + 16'd1;
            else           o_a_count <= o_a_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_oifs_tx_mux.sv
// Bench for oifs_tx_mux: directed table, hand sequences and a queue-based random model.
module tb_oifs_tx_mux;
    localparam int DATA_W  = 8;
    localparam int FIFO_AW = 3;
    localparam int DEPTH   = 1 << FIFO_AW;

    logic              clk = 0;
    logic              arst = 0;
    logic              a_valid = 0, b_valid = 0, rdy = 0;
    logic [DATA_W-1:0] a_data = 0, b_data = 0;
    logic              a_ready, b_ready, o_valid, o_channel;
    logic [DATA_W-1:0] o_data;
`ifdef OIFS_TX_MUX_STATS_EN
    logic [15:0]       a_count, b_count;
`endif

    oifs_tx_mux #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) dut (
        .i_clk(clk), .i_arst(arst),
        .i_a_valid(a_valid), .i_a_data(a_data), .o_a_ready(a_ready),
        .i_b_valid(b_valid), .i_b_data(b_data), .o_b_ready(b_ready),
        .o_valid(o_valid), .o_data(o_data), .o_channel(o_channel),
        .i_ready(rdy)
`ifdef OIFS_TX_MUX_STATS_EN
        , .o_a_count(a_count), .o_b_count(b_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain queues plus the output register contents.
    logic [DATA_W-1:0] qa[$], qb[$];
    logic              m_valid, m_ch, m_last;
    logic [DATA_W-1:0] m_data;
    int                m_ca, m_cb;

    task automatic model_reset();
        qa.delete(); qb.delete();
        m_valid = 0; m_ch = 0; m_last = 1; m_data = 0; m_ca = 0; m_cb = 0;
    endtask

    task automatic model_edge();
        bit ld, pa, pb;
        ld = !m_valid || rdy;
        if (m_valid && rdy) begin
            if (m_ch) m_cb = (m_cb + 1) % 65536;
            else      m_ca = (m_ca + 1) % 65536;
        end
        pa = a_valid && (qa.size() < DEPTH);
        pb = b_valid && (qb.size() < DEPTH);
        if (ld) begin
            if (qa.size() > 0 && (qb.size() == 0 || m_last)) begin
                m_data = qa.pop_front(); m_ch = 0; m_valid = 1; m_last = 0;
            end else if (qb.size() > 0) begin
                m_data = qb.pop_front(); m_ch = 1; m_valid = 1; m_last = 1;
            end else begin
                m_valid = 0;
            end
        end
        if (pa) qa.push_back(a_data);
        if (pb) qb.push_back(b_data);
    endtask

    task automatic do_reset();
        a_valid = 0; b_valid = 0; rdy = 0;
        arst = 1;
        step();
        step();
        arst = 0;
        model_reset();
    endtask

    typedef struct {
        logic              av;
        logic [DATA_W-1:0] ad;
        logic              bv;
        logic [DATA_W-1:0] bd;
        logic              rd;
        logic              ev;
        logic [DATA_W-1:0] ed;
        logic              ec;
        logic              ear;
        logic              ebr;
    } vec_t;

    vec_t tbl[7];
    int   acc;

    initial begin
        // Preload both channels, then drain with ready held high.
        tbl[0] = '{1'b1, 8'h01, 1'b1, 8'h81, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 8'h02, 1'b1, 8'h82, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h82, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h82, 1'b1, 1'b1, 1'b1};

        do_reset();
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_chan", o_channel, 0);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_b_ready", b_ready, 1);

        // Single A word: pushed at one edge, visible after the next.
        a_valid = 1; a_data = 8'h5A; rdy = 1;
        step();
        chk("lat_push_valid", o_valid, 0);
        a_valid = 0;
        step();
        chk("lat_valid", o_valid, 1);
        chk("lat_data", o_data, 8'h5A);
        chk("lat_chan", o_channel, 0);
        step();
        chk("lat_drain_valid", o_valid, 0);

        do_reset();
        for (int i = 0; i < 7; i++) begin
            a_valid = tbl[i].av; a_data = tbl[i].ad;
            b_valid = tbl[i].bv; b_data = tbl[i].bd;
            rdy = tbl[i].rd;
            step();
            chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_data", i), o_data, tbl[i].ed);
            chk($sformatf("tbl%0d_chan", i), o_channel, tbl[i].ec);
            chk($sformatf("tbl%0d_a_ready", i), a_ready, tbl[i].ear);
            chk($sformatf("tbl%0d_b_ready", i), b_ready, tbl[i].ebr);
        end

        // Fill A with output stalled: the output register holds one word, the FIFO the rest.
        do_reset();
        acc = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            a_valid = 1; a_data = 8'h40 + 8'(acc);
            if (a_ready) acc++;
            step();
        end
        a_valid = 0;
        chk("full_accepted", acc, DEPTH + 1);
        chk("full_a_ready", a_ready, 0);
        rdy = 1;
        for (int k = 0; k <= DEPTH; k++) begin
            chk($sformatf("full_drain%0d_valid", k), o_valid, 1);
            chk($sformatf("full_drain%0d_data", k), o_data, 8'h40 + 8'(k));
            step();
        end
        chk("full_drained_valid", o_valid, 0);
        chk("full_a_ready_back", a_ready, 1);

        // Stalled output stays stable while B words arrive.
        do_reset();
        a_valid = 1; a_data = 8'h33;
        step();
        a_valid = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            b_valid = 1; b_data = 8'hB0 + 8'(i);
            step();
            chk($sformatf("stall%0d_valid", i), o_valid, 1);
            chk($sformatf("stall%0d_data", i), o_data, 8'h33);
            chk($sformatf("stall%0d_chan", i), o_channel, 0);
        end
        b_valid = 0; rdy = 1;
        step();
        chk("stall_next_data", o_data, 8'hB0);
        chk("stall_next_chan", o_channel, 1);

        // Reset with words buffered: outputs clear without a clock, nothing replays.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_valid = 1; a_data = 8'hC0 + 8'(i);
            step();
        end
        a_valid = 0;
        #2 arst = 1;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_data", o_data, 0);
        chk("arst_chan", o_channel, 0);
        step();
        arst = 0; rdy = 1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("arst_stale%0d", i), o_valid, 0);
        end

        // Random traffic against the queue model.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            a_valid = 1'($urandom_range(0, 1));
            b_valid = 1'($urandom_range(0, 1));
            a_data  = 8'($urandom);
            b_data  = 8'($urandom);
            rdy     = ((cyc / 200) % 2 == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
            model_edge();
            step();
            chk("rnd_valid", o_valid, m_valid);
            if (m_valid) begin
                chk("rnd_data", o_data, m_data);
                chk("rnd_chan", o_channel, m_ch);
            end
            chk("rnd_a_ready", a_ready, qa.size() < DEPTH);
            chk("rnd_b_ready", b_ready, qb.size() < DEPTH);
`ifdef OIFS_TX_MUX_STATS_EN
            chk("rnd_a_count", a_count, m_ca);
            chk("rnd_b_count", b_count, m_cb);
`endif
        end

`ifdef OIFS_TX_MUX_STATS_EN
        // 0x10001 A transfers wraps the A counter to 1.
        do_reset();
        rdy = 1;
        for (int i = 0; i < 32'h10001; i++) begin
            a_valid = 1; a_data = 8'(i);
            step();
        end
        a_valid = 0;
        for (int i = 0; i < 4; i++) step();
        chk("stats_a_wrap", a_count, 16'd1);
        chk("stats_b_zero", b_count, 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
